// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared y86 definitions used by the write-back port
//                scheduler. Holds the "no destination" register id, the
//                scheduler state enumeration and helpers that turn a
//                register id into a liveness flag or a pending-mask bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Register id meaning "no destination register".
  localparam int REG_NONE = 15;

  // Number of architectural registers that can be tracked as pending.
  localparam int c_NUM_PEND = 15;

  // Write-back scheduler states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_A = 2'd1,
    WR_B = 2'd2
  } wb_state_t;

  // A destination produces a register write only when it is not the
  // "none" id and addresses one of the trackable registers. Ids at or
  // above c_NUM_PEND can appear when the id field is wider than 4 bits;
  // those are treated exactly like "none".
  function automatic logic dst_live(input logic [31:0] dst,
                                    input logic [31:0] none);
    return (dst != none) && (dst < 32'(c_NUM_PEND));
  endfunction

  // One-hot pending-mask bit for a destination, zero when not live.
  function automatic logic [c_NUM_PEND-1:0] dst_onehot(input logic [31:0] dst,
                                                       input logic [31:0] none);
    logic [c_NUM_PEND-1:0] m;
    m = '0;
    if (dst_live(dst, none)) begin
      m = c_NUM_PEND'(1) << dst[3:0];
    end
    return m;
  endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/wb_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_sched
//  Description : Write-back port scheduler. Accepts a request carrying up to
//                two destination writes (A and B) and serialises them onto a
//                single register-file write port, one write per cycle.
//                When both destinations name the same register only the B
//                write is issued (B data wins).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   1       clock, rising edge
//    rst_n      in   1       synchronous active-low reset
//    in_valid   in   1       write-back request present
//    in_ready   out  1       request can be accepted this cycle
//    in_dstA    in   REG_W   first destination id (REG_NONE = none)
//    in_dataA   in   DATA_W  first write data
//    in_dstB    in   REG_W   second destination id (REG_NONE = none)
//    in_dataB   in   DATA_W  second write data
//    rf_we      out  1       register-file write enable
//    rf_waddr   out  REG_W   register-file write address (0 when idle)
//    rf_wdata   out  DATA_W  register-file write data (0 when idle)
//    pend_mask  out  15      registers with a held, not yet issued write
//    busy       out  1       scheduler is not idle
//    wr_count   out  16      saturating count of issued writes
// ============================================================================
module wb_port_sched #(
  parameter int DATA_W   = 64,
  parameter int REG_W    = 4,
  parameter int REG_NONE = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_dstA,
  input  logic [DATA_W-1:0] in_dataA,
  input  logic [REG_W-1:0]  in_dstB,
  input  logic [DATA_W-1:0] in_dataB,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [14:0]       pend_mask,
  output logic              busy,
  output logic [15:0]       wr_count
);

  import y86_pkg::*;

  localparam logic [31:0]      c_NONE    = 32'(REG_NONE);
  localparam logic [REG_W-1:0] c_NONE_ID = REG_W'(REG_NONE);
  localparam logic [15:0]      c_CNT_MAX = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State and holding registers
  // --------------------------------------------------------------------------
  wb_state_t          r_state;
  logic [REG_W-1:0]   r_a_dst;
  logic [DATA_W-1:0]  r_a_data;
  logic [REG_W-1:0]   r_b_dst;
  logic [DATA_W-1:0]  r_b_data;
  logic [14:0]        r_pend;
  logic [15:0]        r_wr_count;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic               w_in_a_live;
  logic               w_in_b_live;
  logic               w_issue_a;
  logic               w_issue_b;
  logic               w_hb_pending;
  logic               w_ready;
  logic               w_accept;
  logic               w_writing;
  wb_state_t          w_acc_state;
  logic [14:0]        w_set;
  logic [14:0]        w_clr;

  always_comb begin
    w_in_a_live  = dst_live(32'(in_dstA), c_NONE);
    w_in_b_live  = dst_live(32'(in_dstB), c_NONE);

    // A is dropped on a collision so the single surviving write carries B data.
    w_issue_a    = w_in_a_live && (in_dstA != in_dstB);
    w_issue_b    = w_in_b_live;

    // Held B destinations are stored as REG_NONE when they will not issue,
    // so liveness of r_b_dst alone says whether WR_B must follow WR_A.
    w_hb_pending = dst_live(32'(r_b_dst), c_NONE);

    // The port can take a new request whenever the current cycle's write is
    // the last one outstanding (or there is none).
    w_ready      = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      WR_A:    w_ready = !w_hb_pending;
      WR_B:    w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase

    // Reset dominates: a request presented during reset is never taken.
    w_accept     = rst_n && in_valid && w_ready;

    w_acc_state  = IDLE;
    if (w_issue_a) begin
      w_acc_state = WR_A;
    end else if (w_issue_b) begin
      w_acc_state = WR_B;
    end

    w_writing    = (r_state == WR_A) || (r_state == WR_B);

    // Bit of the write issuing this cycle; it retires on the closing edge.
    w_clr        = '0;
    case (r_state)
      WR_A:    w_clr = dst_onehot(32'(r_a_dst), c_NONE);
      WR_B:    w_clr = dst_onehot(32'(r_b_dst), c_NONE);
      default: w_clr = '0;
    endcase

    // Bits for the writes of a request being accepted on this edge.
    w_set        = '0;
    if (w_accept) begin
      if (w_issue_a) begin
        w_set = w_set | dst_onehot(32'(in_dstA), c_NONE);
      end
      if (w_issue_b) begin
        w_set = w_set | dst_onehot(32'(in_dstB), c_NONE);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a_dst    <= '0;
      r_a_data   <= '0;
      r_b_dst    <= '0;
      r_b_data   <= '0;
      r_pend     <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_accept) begin
        r_a_dst  <= w_issue_a ? in_dstA : c_NONE_ID;
        r_a_data <= in_dataA;
        r_b_dst  <= w_issue_b ? in_dstB : c_NONE_ID;
        r_b_data <= in_dataB;
      end

      case (r_state)
        IDLE: begin
          r_state <= w_accept ? w_acc_state : IDLE;
        end
        WR_A: begin
          if (w_hb_pending) begin
            r_state <= WR_B;
          end else begin
            r_state <= w_accept ? w_acc_state : IDLE;
          end
        end
        WR_B: begin
          r_state <= w_accept ? w_acc_state : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Set after clear so a re-accept of the retiring register keeps it set.
      r_pend <= (r_pend & ~w_clr) | w_set;

      if (w_writing && (r_wr_count != c_CNT_MAX)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived directly from registered state
  // --------------------------------------------------------------------------
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    case (r_state)
      WR_A: begin
        rf_waddr = r_a_dst;
        rf_wdata = r_a_data;
      end
      WR_B: begin
        rf_waddr = r_b_dst;
        rf_wdata = r_b_data;
      end
      default: begin
        rf_waddr = '0;
        rf_wdata = '0;
      end
    endcase
  end

  assign in_ready  = w_ready;
  assign rf_we     = w_writing;
  assign busy      = (r_state != IDLE);
  assign pend_mask = r_pend;
  assign wr_count  = r_wr_count;

endmodule : wb_port_sched
`default_nettype wire

// File: tb/tb_wb_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_sched
//  Description : Self-checking bench for wb_port_sched. The reference model
//                is a queue of register writes still owed by the port: each
//                accepted request appends its writes, and the port must drain
//                the queue one entry per cycle. Readiness, busy, pending mask
//                and the write counter all follow from the queue contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_sched;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dstA;
  logic [63:0] in_dataA;
  logic [3:0]  in_dstB;
  logic [63:0] in_dataB;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [14:0] pend_mask;
  logic        busy;
  logic [15:0] wr_count;

  wb_port_sched #(
    .DATA_W   (64),
    .REG_W    (4),
    .REG_NONE (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dstA   (in_dstA),
    .in_dataA  (in_dataA),
    .in_dstB   (in_dstB),
    .in_dataB  (in_dataB),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mdl_count;
  logic        mdl_ready;
  logic        mon_en;
  int          n_checks;
  int          n_pass;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Monitor: compares each cycle's outputs with the head of the owed-write
  // queue, then retires that write.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [14:0] m;
      logic        exp_we;
      wr_t         h;
      m = '0;
      foreach (exp_q[i]) m = m | (15'(1) << exp_q[i].addr);
      exp_we = (exp_q.size() > 0);
      chk("rf_we",     64'(rf_we),     64'(exp_we));
      chk("busy",      64'(busy),      64'(exp_we));
      chk("in_ready",  64'(in_ready),  64'(exp_q.size() <= 1));
      chk("pend_mask", 64'(pend_mask), 64'(m));
      chk("wr_count",  64'(wr_count),  64'(mdl_count));
      if (exp_we) begin
        h = exp_q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(h.addr));
        chk("rf_wdata", rf_wdata, h.data);
        if (mdl_count != 16'hFFFF) mdl_count = mdl_count + 16'd1;
      end else begin
        chk("rf_waddr_idle", 64'(rf_waddr), 64'd0);
        chk("rf_wdata_idle", rf_wdata, 64'd0);
      end
      mdl_ready = (exp_q.size() == 0);
    end
  end

  // One cycle of stimulus; the model records the request's writes on the
  // accepting edge.
  task automatic do_cycle(input logic v, input logic [3:0] da,
                          input logic [63:0] xa, input logic [3:0] db,
                          input logic [63:0] xb, input logic rn);
    logic acc;
    @(negedge clk);
    #1;
    rst_n    = rn;
    in_valid = v;
    in_dstA  = da;
    in_dataA = xa;
    in_dstB  = db;
    in_dataB = xb;
    acc      = rn && v && mdl_ready;
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      mdl_count = '0;
    end else if (acc) begin
      if (da != 4'd15 && da != db) exp_q.push_back('{addr: da, data: xa});
      if (db != 4'd15)             exp_q.push_back('{addr: db, data: xb});
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1);
  endtask

  initial begin
    logic [3:0]  da;
    logic [3:0]  db;
    logic [63:0] xa;
    logic [63:0] xb;
    logic        v;
    logic        rn;
    n_checks  = 0;
    n_pass    = 0;
    mdl_count = '0;
    mdl_ready = 1'b1;
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_dstA   = 4'd15;
    in_dataA  = '0;
    in_dstB   = 4'd15;
    in_dataB  = '0;

    // Reset with a request presented: it must not be taken.
    do_cycle(1'b1, 4'd6, 64'h66, 4'd15, 64'd0, 1'b0);
    do_cycle(1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0);
    mon_en = 1'b1;
    idle(2);

    // Single write
    do_cycle(1'b1, 4'd3, 64'h11, 4'd15, 64'd0, 1'b1);
    idle(3);
    // Dual write
    do_cycle(1'b1, 4'd14, 64'h100, 4'd2, 64'hAB, 1'b1);
    idle(3);
    // Collision: B wins
    do_cycle(1'b1, 4'd5, 64'h1, 4'd5, 64'h2, 1'b1);
    idle(3);
    // No-op
    do_cycle(1'b1, 4'd15, 64'h5, 4'd15, 64'h6, 1'b1);
    idle(3);
    // Streaming singles
    for (int k = 1; k <= 4; k++) do_cycle(1'b1, 4'(k), 64'(k * 16'h101), 4'd15, 64'd0, 1'b1);
    idle(3);
    // Reset during WR_A of a dual write
    do_cycle(1'b1, 4'd7, 64'h77, 4'd8, 64'h88, 1'b1);
    do_cycle(1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0);
    idle(3);
    // Back-to-back dual followed by retry while busy
    do_cycle(1'b1, 4'd9, 64'h99, 4'd10, 64'hAA, 1'b1);
    do_cycle(1'b1, 4'd11, 64'hBB, 4'd15, 64'd0, 1'b1);
    do_cycle(1'b1, 4'd11, 64'hBB, 4'd15, 64'd0, 1'b1);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r  = $urandom_range(0, 9);
      da = (r < 2) ? 4'd15 : 4'($urandom_range(0, 15));
      r  = $urandom_range(0, 9);
      db = (r < 2) ? 4'd15 : (r == 2) ? da : 4'($urandom_range(0, 15));
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      v  = ($urandom_range(0, 9) < 7);
      rn = ($urandom_range(0, 59) != 0);
      do_cycle(v, da, xa, db, xb, rn);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wb_port_sched
`default_nettype wire

// File: doc/wb_port_sched.md
WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 64, register data width
- REG_W, 4, register-id width
- REG_NONE, 15, "no destination" id
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  write-back request present
- in_ready  out  1  scheduler can accept a request this cycle
- in_dstA  in  REG_W  first destination id (REG_NONE = none)
- in_dataA  in  DATA_W  first write data
- in_dstB  in  REG_W  second destination id (REG_NONE = none)
- in_dataB  in  DATA_W  second write data
- rf_we  out  1  register-file write enable, single write port
- rf_waddr  out  REG_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- pend_mask  out  15  bit r set while a write to register r is held but not yet issued
- busy  out  1  state is not IDLE
- wr_count  out  16  issued-write counter, saturating

Function
REQ-003 A request SHALL be accepted on a rising edge where in_valid && in_ready; dst/data SHALL be latched into holding registers hA/hB.
REQ-004 States SHALL be IDLE, WR_A and WR_B; rf_we SHALL be 1 only in WR_A or WR_B, with address/data taken from hA or hB respectively.
REQ-005 On accept, next state SHALL be: WR_A if dstA!=REG_NONE and dstA!=dstB; else WR_B if dstB!=REG_NONE; else IDLE (request consumed, no write).
REQ-006 If dstA==dstB!=REG_NONE, only the B write SHALL issue (B data wins).
REQ-007 From WR_A, next state SHALL be WR_B if hB.dst!=REG_NONE; else per REQ-008.
REQ-008 From WR_B, or from WR_A with no B write pending: if a request is accepted that cycle, next state SHALL follow REQ-005 for the new request; else IDLE.
REQ-009 in_ready SHALL be 1 in IDLE, in WR_B, and in WR_A when hB.dst==REG_NONE; 0 otherwise.
REQ-010 Latency: a request accepted at edge N SHALL write its first register in cycle N+1. A dual write SHALL occupy cycles N+1 and N+2. Back-to-back single writes SHALL sustain one write per cycle.
REQ-011 pend_mask SHALL be set on the accept edge for every destination that will issue (per REQ-005/006). Each bit SHALL clear on the edge ending its write cycle. A bit set by a new accept in the same cycle takes priority over a clear.
REQ-012 Register ids >= 15 SHALL never assert pend_mask bits or rf_we.
REQ-013 wr_count SHALL increment by 1 on each edge where rf_we=1 and SHALL saturate at 16'hFFFF.
REQ-014 rf_waddr and rf_wdata SHALL be 0 whenever rf_we=0.

Reset
REQ-015 While rst_n=0 at a rising edge: state SHALL go to IDLE; hA/hB, pend_mask and wr_count SHALL clear. The next cycle SHALL have rf_we=0, busy=0 and in_ready=1.
REQ-016 Reset asserted mid-operation SHALL discard any unissued held write. No partial write SHALL occur in the cycle following the reset edge.
REQ-017 A request presented while rst_n=0 SHALL not be accepted.

Structure
REQ-018 REG_NONE and the state enumeration (IDLE, WR_A, WR_B) SHALL live in the shared y86 package and be imported here.
REQ-019 The block SHALL be a single module with no sub-modules; the register file remains external.

Verification
REQ-020 Verification SHALL cover:
- Single write: accept dstA=3, dataA=0x11, dstB=15 -> one cycle of rf_we=1, waddr=3, wdata=0x11. pend_mask[3] high for exactly one cycle. wr_count=1.
- Dual write (popq-style): dstA=14 dataA=0x100, dstB=2 dataB=0xAB -> writes 14 then 2 on consecutive cycles; in_ready=0 during WR_A.
- Collision: dstA=dstB=5, dataA=0x1, dataB=0x2 -> exactly one write, waddr=5, wdata=0x2.
- No-op: dstA=dstB=15 -> rf_we stays 0; state stays IDLE; in_ready stays 1.
- Streaming: 4 back-to-back single writes to regs 1..4 -> rf_we high for 4 consecutive cycles; wr_count=4.
- Reset mid-op: accept dual write {7,8}, assert rst_n=0 during WR_A -> register 8 never written; pend_mask=0; busy=0 after the edge.
